id_exe_pipe_buffer: RTL and testbench

- Parametrised successor to the single-entry ID/EXE stage register.
- Holds decoded ID-stage payloads in a DEPTH-entry circular buffer with valid/ready handshake on both sides.
- Supports flush, freeze and hazard bubble insertion, so that ID and EXE can stall independently.
- Sits between the ID stage combinational decode and the EXE stage. Payload is the concatenated control/data bundle (pc, control bits, reg values, dest, immediates, src addresses, status).

---
 rtl/id_exe_pipe_buffer.sv | 133 +++++++++++++
 tb/tb_id_exe_pipe_buffer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_pipe_buffer.sv
// id_exe_pipe_buffer: DEPTH-entry circular buffer between the ID-stage decode
// and the EXE stage, with valid/ready handshake on both sides plus flush,
// freeze and hazard control so ID and EXE can stall independently.
//
// Optional statistics (bubble_count, high_water) are built only when the
// macro ID_EXE_BUFFER_STATS_EN is defined; otherwise both outputs read 0.
module id_exe_pipe_buffer #(
    parameter int unsigned DATA_W = 146,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       freeze,
    input  logic                       hazard,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic [CNT_W-1:0]           bubble_count,
    output logic [$clog2(DEPTH):0]     high_water
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              push;
    logic              pop;

    // Handshake qualification; flush removes both push and pop.
    always_comb begin
        in_ready  = (occ_q < FULL_OCC) && !hazard && !flush;
        out_valid = (occ_q != '0);
        out_data  = mem_q[rd_ptr_q];
        occupancy = occ_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready && !freeze && !flush;
    end

    // Next pointer and occupancy values; DEPTH is a power of two so the
    // pointers wrap naturally at their own width.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occ_d = occ_q + OCC_W'(1);
                2'b01:   occ_d = occ_q - OCC_W'(1);
                default: occ_d = occ_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    // Payload storage; cleared on reset so out_data reads 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef ID_EXE_BUFFER_STATS_EN
    logic [CNT_W-1:0] bubble_q;
    logic [OCC_W-1:0] hw_q;

    // EXE-starve counter, saturating; untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bubble_q <= '0;
        end else if (out_ready && !freeze && !out_valid && (bubble_q != '1)) begin
            bubble_q <= bubble_q + CNT_W'(1);
        end
    end

    // Peak occupancy tracker; untouched by flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hw_q <= '0;
        end else if (occ_q > hw_q) begin
            hw_q <= occ_q;
        end
    end

    assign bubble_count = bubble_q;
    assign high_water   = hw_q;
`else
    assign bubble_count = '0;
    assign high_water   = '0;
`endif

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (occ_q == FULL_OCC)));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
        !(pop && (occ_q == '0)));

endmodule

// File: tb/tb_id_exe_pipe_buffer.sv
// Bench for id_exe_pipe_buffer (DEPTH=4): directed scenarios followed by
// random traffic, compared against a queue-based reference model.
module tb_id_exe_pipe_buffer;

    localparam int unsigned DATA_W = 146;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              freeze;
    logic              hazard;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  bubble_count;
    logic [OCC_W-1:0]  high_water;

    id_exe_pipe_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .freeze       (freeze),
        .hazard       (hazard),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .occupancy    (occupancy),
        .bubble_count (bubble_count),
        .high_water   (high_water)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO contents plus statistics.
    logic [DATA_W-1:0] model_q[$];
    int unsigned       m_bub;
    int unsigned       m_hw;
    logic [DATA_W-1:0] flushed_val;

    int n_vec;
    int n_err;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_data();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DATA_W-1:0];
    endfunction

    task automatic chk_stats();
`ifdef ID_EXE_BUFFER_STATS_EN
        chk("bubble_count", DATA_W'(bubble_count), DATA_W'(m_bub));
        chk("high_water", DATA_W'(high_water), DATA_W'(m_hw));
`else
        chk("bubble_count", DATA_W'(bubble_count), '0);
        chk("high_water", DATA_W'(high_water), '0);
`endif
    endtask

    // One clock cycle: drive after negedge, check combinational outputs,
    // then advance the model to reflect the coming posedge.
    task automatic step(input logic iv, input logic [DATA_W-1:0] d,
                        input logic ordy, input logic frz,
                        input logic hz, input logic fl);
        int unsigned sz;
        logic        exp_rdy;
        logic        do_push;
        logic        do_pop;
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        freeze    = frz;
        hazard    = hz;
        flush     = fl;
        #1;
        sz      = model_q.size();
        exp_rdy = (sz < DEPTH) && !hz && !fl;
        chk("in_ready", DATA_W'(in_ready), DATA_W'(exp_rdy));
        chk("occupancy", DATA_W'(occupancy), DATA_W'(sz));
        chk("out_valid", DATA_W'(out_valid), DATA_W'(sz != 0));
        if (sz != 0) begin
            chk("out_data", out_data, model_q[0]);
        end
        chk_stats();
        if (sz != 0 && fl == 1'b0 && flushed_val != '0) begin
            chk("flushed_never_out", DATA_W'(out_data == flushed_val), '0);
        end
        do_push = iv && exp_rdy;
        do_pop  = (sz != 0) && ordy && !frz;
        if (ordy && !frz && sz == 0 && m_bub < (2**CNT_W - 1)) begin
            m_bub++;
        end
        if (sz > m_hw) begin
            m_hw = sz;
        end
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
            end
            if (do_push) begin
                model_q.push_back(d);
            end
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, '0, ordy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_occ"}, DATA_W'(occupancy), '0);
        chk({tag, "_out_valid"}, DATA_W'(out_valid), '0);
        chk({tag, "_out_data"}, out_data, '0);
        chk({tag, "_bubble"}, DATA_W'(bubble_count), '0);
        chk({tag, "_hw"}, DATA_W'(high_water), '0);
    endtask

    initial begin
        logic [DATA_W-1:0] v;
        n_vec       = 0;
        n_err       = 0;
        m_bub       = 0;
        m_hw        = 0;
        flushed_val = '0;
        rst         = 1'b0;
        flush       = 1'b0;
        freeze      = 1'b0;
        hazard      = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;

        // Power-on reset
        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("por");
        rst = 1'b1;

        // Fill to DEPTH with out_ready=0, then drain in order
        step(1'b1, DATA_W'(32'hA), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, DATA_W'(32'hB), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, DATA_W'(32'hC), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, DATA_W'(32'hD), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, DATA_W'(32'hE), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) idle(1'b1);

        // Freeze with head 0xA while pushes keep arriving
        step(1'b1, DATA_W'(32'hA), 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, rnd_data(), 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (6) idle(1'b1);

        // Flush with concurrent push and pop at occupancy 1
        step(1'b1, DATA_W'(32'h11), 1'b0, 1'b0, 1'b0, 1'b0);
        flushed_val = DATA_W'(32'hF1F1);
        step(1'b1, flushed_val, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        step(1'b1, DATA_W'(32'h22), 1'b0, 1'b0, 1'b0, 1'b0);
        // Flush together with freeze on a non-empty buffer
        step(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // Hazard with in_valid on an empty buffer
        step(1'b1, DATA_W'(32'h33), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, DATA_W'(32'h33), 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, DATA_W'(32'h33), 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Wrap-around: 10 interleaved pushes with occasional pops
        for (int i = 0; i < 10; i++) begin
            step(1'b1, DATA_W'(32'h100 + i), (i % 3) == 2, 1'b0, 1'b0, 1'b0);
        end
        repeat (6) idle(1'b1);

        // Asynchronous reset mid-stream with 2 entries buffered
        step(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, rnd_data(), 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_reset_occ", DATA_W'(occupancy), DATA_W'(2));
        #1;
        rst = 1'b0;
        #1;
        chk_reset_state("async");
        model_q.delete();
        m_bub = 0;
        m_hw  = 0;
        @(negedge clk);
        rst = 1'b1;
        v = rnd_data();
        step(1'b1, v, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        chk("post_reset_head", out_data, v);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, rnd_data(),
                 $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 6) == 0, $urandom_range(0, 24) == 0);
        end
        repeat (6) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
